// File: rtl/spi_tx_sequencer_if.sv
// Byte-queue write port and SPI-master handshake bundle for spi_tx_sequencer.
interface spi_tx_sequencer_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [7:0]    wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic          flush;
  logic [7:0]    tx_data_reg;
  logic          start_transfer;
  logic          done;
  logic [LW-1:0] level;
  logic          busy;

  // Producer / SPI-master side
  modport master (
    output wr_data, wr_valid, flush, done,
    input  wr_ready, tx_data_reg, start_transfer, level, busy
  );

  // Sequencer side
  modport slave (
    input  wr_data, wr_valid, flush, done,
    output wr_ready, tx_data_reg, start_transfer, level, busy
  );
endinterface

// File: rtl/spi_tx_sequencer.sv
// Byte queue that feeds an SPI master one byte at a time with a fixed idle gap.
module spi_tx_sequencer #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned GAP_CYCLES = 2
) (
  input logic               clk,
  input logic               rst_n,
  spi_tx_sequencer_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(GAP_CYCLES + 2);

  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [LW-1:0] w_level_nxt;
  logic [CW-1:0] r_gap_cnt;
  logic [CW-1:0] w_gap_cnt_nxt;
  logic [7:0]    r_tx_data;
  logic          r_start;
  logic          r_busy;
  logic          r_wr_ready;
  logic          w_wr_en;
  logic          w_pop;

  // Flush wins over a coincident write
  assign w_wr_en = bus.wr_valid && r_wr_ready && !bus.flush;

  // State and gap-counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
    end
  end

  // Next-state logic; done only matters while waiting on the SPI master
  always_comb begin
    w_state_nxt   = r_state;
    w_gap_cnt_nxt = r_gap_cnt;
    w_pop         = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_level != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.done) begin
          if (GAP_CYCLES > 0) begin
            w_state_nxt   = GAP;
            w_gap_cnt_nxt = CW'(GAP_CYCLES);
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      GAP: begin
        if (r_gap_cnt <= CW'(1)) begin
          w_state_nxt   = IDLE;
          w_gap_cnt_nxt = '0;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - CW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Occupancy after this edge; a pop that coincides with flush still happens
  always_comb begin
    w_level_nxt = r_level;
    if (bus.flush) begin
      w_level_nxt = '0;
    end else if (w_wr_en && !w_pop) begin
      w_level_nxt = r_level + LW'(1);
    end else if (!w_wr_en && w_pop) begin
      w_level_nxt = r_level - LW'(1);
    end
  end

  // Queue pointers and level; flush snaps the read pointer to the tail
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      r_level <= w_level_nxt;
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (bus.flush) begin
        r_rd_ptr <= r_wr_ptr;
      end else if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  // Byte storage
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= bus.wr_data;
    end
  end

  // Registered outputs, computed from the post-edge state so they line up with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_data  <= 8'h00;
      r_start    <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_ready <= 1'b1;
    end else begin
      if (w_pop) begin
        r_tx_data <= r_mem[r_rd_ptr];
      end
      r_start    <= (w_state_nxt == START);
      r_busy     <= (w_state_nxt != IDLE) || (w_level_nxt != '0);
      r_wr_ready <= (w_level_nxt != LW'(DEPTH));
    end
  end

  assign bus.wr_ready       = r_wr_ready;
  assign bus.tx_data_reg    = r_tx_data;
  assign bus.start_transfer = r_start;
  assign bus.level          = r_level;
  assign bus.busy           = r_busy;

endmodule

// File: tb/tb_spi_tx_sequencer.sv
// Self-checking bench for spi_tx_sequencer: queue/timeline model plus directed scenarios.
module tb_spi_tx_sequencer;

  localparam int DEPTH = 8;
  localparam int GAP   = 2;
  localparam int DLY   = 100;

  logic clk = 1'b0;
  logic rst_n;
  logic done_force = 1'b0;
  logic done_auto  = 1'b0;
  logic auto_done  = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  spi_tx_sequencer_if #(.DEPTH(DEPTH)) bus ();

  spi_tx_sequencer #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.done = done_force | done_auto;

  always #5 clk = ~clk;

  // Model: edge counter, queue contents, in-flight byte and earliest next-pop edge
  int         m_cyc = 0;
  logic [7:0] m_q[$];
  bit         m_inflight = 1'b0;
  int         m_pop_edge = -100;
  int         m_next_ok = 0;
  int         last_done_cyc = -100;
  logic [7:0] m_tx = 8'h00;
  bit         m_start = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    bit acc;
    bit pop;
    bit wr;
    if (!rst_n) begin
      m_q.delete();
      m_inflight = 1'b0;
      m_pop_edge = -100;
      m_next_ok  = 0;
      m_tx       = 8'h00;
      m_start    = 1'b0;
    end else begin
      m_cyc++;
      acc = m_inflight && (bus.done === 1'b1) && (m_cyc >= m_pop_edge + 2);
      pop = !m_inflight && (m_cyc >= m_next_ok) && (m_q.size() > 0);
      wr  = (bus.wr_valid === 1'b1) && (m_q.size() < DEPTH) && (bus.flush !== 1'b1);
      m_start = 1'b0;
      if (acc) begin
        m_inflight    = 1'b0;
        m_next_ok     = m_cyc + GAP + 1;
        last_done_cyc = m_cyc;
      end
      if (pop) begin
        m_tx       = m_q.pop_front();
        m_inflight = 1'b1;
        m_pop_edge = m_cyc;
        m_start    = 1'b1;
      end
      if (bus.flush === 1'b1) m_q.delete();
      else if (wr) m_q.push_back(bus.wr_data);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model; also logs each transmitted byte
  logic [7:0] sent[$];
  always @(negedge clk) begin
    int exp_busy;
    exp_busy = int'(m_inflight || (m_cyc < m_next_ok - 1) || (m_q.size() != 0));
    check("cyc_tx_data_reg", int'(bus.tx_data_reg), int'(m_tx));
    check("cyc_start_transfer", int'(bus.start_transfer), int'(m_start));
    check("cyc_level", int'(bus.level), m_q.size());
    check("cyc_wr_ready", int'(bus.wr_ready), int'(m_q.size() != DEPTH));
    check("cyc_busy", int'(bus.busy), exp_busy);
    if (bus.start_transfer === 1'b1) sent.push_back(bus.tx_data_reg);
  end

  // SPI master stand-in: answers each start with done DLY cycles later
  initial begin
    forever begin
      @(negedge clk);
      if (auto_done && bus.start_transfer === 1'b1) begin
        repeat (DLY - 1) @(negedge clk);
        #1 done_auto = 1'b1;
        @(negedge clk);
        #1 done_auto = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    tick(1);
    bus.wr_valid = 1'b0;
  endtask

  task automatic pulse_done();
    done_force = 1'b1;
    tick(1);
    done_force = 1'b0;
  endtask

  int peak;

  task automatic run_until_idle(input int budget, input bit spacing);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < budget) begin
      tick(1);
      n++;
      if (int'(bus.level) > peak) peak = int'(bus.level);
      if (spacing && bus.start_transfer === 1'b1)
        check("start_after_done", m_cyc - last_done_cyc, GAP + 1);
    end
    if (n >= budget) check("idle_timeout", n, 0);
  endtask

  int base;

  initial begin
    rst_n        = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = 8'h00;
    bus.flush    = 1'b0;
    tick(2);

    // Reset values
    check("rst_level", int'(bus.level), 0);
    check("rst_wr_ready", int'(bus.wr_ready), 1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_tx_data", int'(bus.tx_data_reg), 0);
    check("rst_start", int'(bus.start_transfer), 0);

    // Single byte; written on the very first edge after release
    rst_n = 1'b1;
    wr(8'hA5);
    check("single_level", int'(bus.level), 1);
    check("single_start_early", int'(bus.start_transfer), 0);
    tick(1);
    check("single_tx", int'(bus.tx_data_reg), 8'hA5);
    check("single_start", int'(bus.start_transfer), 1);
    tick(1);
    check("single_start_one_cycle", int'(bus.start_transfer), 0);
    pulse_done();
    check("single_gap1_busy", int'(bus.busy), 1);
    tick(1);
    check("single_gap2_busy", int'(bus.busy), 1);
    tick(1);
    check("single_idle_busy", int'(bus.busy), 0);
    check("single_tx_hold", int'(bus.tx_data_reg), 8'hA5);

    // Burst 01..08 with the auto responder
    tick(3);
    peak = 0;
    base = sent.size();
    auto_done = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      wr(8'(i));
      if (int'(bus.level) > peak) peak = int'(bus.level);
    end
    run_until_idle(3000, 1'b1);
    auto_done = 1'b0;
    check("burst_peak_level", peak, 7);
    check("burst_count", sent.size() - base, 8);
    if (sent.size() - base == 8)
      for (int k = 0; k < 8; k++) check("burst_order", int'(sent[base + k]), k + 1);

    // Full queue: one byte in flight plus eight queued, then FF must bounce
    tick(3);
    base = sent.size();
    for (int i = 0; i < 9; i++) wr(8'h10 + 8'(i));
    check("full_level", int'(bus.level), 8);
    check("full_wr_ready", int'(bus.wr_ready), 0);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'hFF;
    tick(4);
    bus.wr_valid = 1'b0;
    check("full_level_hold", int'(bus.level), 8);
    check("full_wr_ready_hold", int'(bus.wr_ready), 0);
    pulse_done();
    auto_done = 1'b1;
    peak = 0;
    run_until_idle(3000, 1'b1);
    auto_done = 1'b0;
    check("full_count", sent.size() - base, 9);
    if (sent.size() - base == 9)
      for (int k = 0; k < 9; k++) check("full_order", int'(sent[base + k]), 8'h10 + k);

    // Flush mid-transfer, with a coincident write that must be dropped
    tick(3);
    base = sent.size();
    wr(8'h31);
    wr(8'h32);
    wr(8'h33);
    tick(2);
    check("flush_pre_level", int'(bus.level), 2);
    bus.flush    = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h99;
    tick(1);
    bus.flush    = 1'b0;
    bus.wr_valid = 1'b0;
    check("flush_level", int'(bus.level), 0);
    check("flush_busy_inflight", int'(bus.busy), 1);
    tick(3);
    pulse_done();
    tick(20);
    check("flush_no_more_starts", sent.size() - base, 1);
    check("flush_tx_kept", int'(bus.tx_data_reg), 8'h31);
    check("flush_idle", int'(bus.busy), 0);

    // Spurious done in IDLE and in START
    pulse_done();
    tick(1);
    check("spur_idle_busy", int'(bus.busy), 0);
    base = sent.size();
    wr(8'h5A);
    tick(1);
    check("spur_start_high", int'(bus.start_transfer), 1);
    pulse_done();
    check("spur_start_low", int'(bus.start_transfer), 0);
    tick(5);
    check("spur_still_waiting", int'(bus.busy), 1);
    pulse_done();
    tick(5);
    check("spur_one_start", sent.size() - base, 1);
    check("spur_idle_after", int'(bus.busy), 0);

    // Asynchronous reset mid-WAIT with bytes still queued
    wr(8'h77);
    wr(8'h78);
    wr(8'h79);
    tick(2);
    #1 rst_n = 1'b0;
    #1;
    check("arst_tx", int'(bus.tx_data_reg), 0);
    check("arst_start", int'(bus.start_transfer), 0);
    check("arst_level", int'(bus.level), 0);
    check("arst_wr_ready", int'(bus.wr_ready), 1);
    check("arst_busy", int'(bus.busy), 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check("arst_empty_level", int'(bus.level), 0);
    check("arst_empty_busy", int'(bus.busy), 0);
    pulse_done();
    tick(1);
    check("arst_late_done", int'(bus.busy), 0);
    wr(8'hC3);
    tick(1);
    check("arst_resume_tx", int'(bus.tx_data_reg), 8'hC3);
    tick(1);
    pulse_done();
    tick(5);
    check("arst_resume_idle", int'(bus.busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_tx_sequencer.md
SPI_TX_SEQUENCER -- requirements
Module: spi_tx_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning byte-queue depth (power of two, >= 2).
REQ-002 SHALL have parameter GAP_CYCLES, default 2, meaning idle clk cycles between the done of one byte and the next pop (0 allowed).
REQ-003 SHALL have the port clk  input  1  the single system clock; all logic is on its rising edge.
REQ-004 SHALL have the port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have the port wr_data  input  8  byte to enqueue.
REQ-006 SHALL have the port wr_valid  input  1  enqueue request.
REQ-007 SHALL have the port wr_ready  output  1  queue can accept a byte.
REQ-008 SHALL have the port flush  input  1  synchronous discard of all queued, not-yet-popped bytes.
REQ-009 SHALL have the port tx_data_reg  output  8  byte presented to the downstream SPI master.
REQ-010 SHALL have the port start_transfer  output  1  one-cycle transfer request to the SPI master.
REQ-011 SHALL have the port done  input  1  one-cycle end-of-byte pulse from the SPI master.
REQ-012 SHALL have the port level  output  $clog2(DEPTH)+1  number of queued bytes.
REQ-013 SHALL have the port busy  output  1  queue non-empty or a byte in flight.

Function
REQ-014 SHALL accept a byte at a rising edge where wr_valid=1 and wr_ready=1, writing it at the tail.
REQ-015 SHALL drive wr_ready = (level != DEPTH), from registered state only, with no combinational path from wr_valid or done.
REQ-016 SHALL ignore wr_valid while wr_ready=0: no write, no pointer change, level unchanged.
REQ-017 SHALL use wrapping read/write pointers of $clog2(DEPTH) bits; level = writes - pops, range 0..DEPTH.
REQ-018 SHALL implement FSM states IDLE, START, WAIT, GAP.
REQ-019 In IDLE with level>0, it SHALL pop the head into tx_data_reg at the next edge and enter START.
REQ-020 In START, it SHALL hold start_transfer=1 for exactly one cycle, then enter WAIT.
REQ-021 In WAIT, it SHALL keep start_transfer=0 and hold tx_data_reg stable; on done=1 it SHALL enter GAP if GAP_CYCLES>0, else IDLE.
REQ-022 In GAP, it SHALL count GAP_CYCLES cycles, then enter IDLE.
REQ-023 SHALL ignore done in any state other than WAIT.
REQ-024 SHALL keep tx_data_reg unchanged from the START entry edge until the next pop.
REQ-025 Latency: a byte written into an empty queue in IDLE at edge N SHALL be popped at edge N+1, with start_transfer high for the cycle following edge N+1.
REQ-026 A simultaneous write and pop SHALL leave level unchanged and lose neither byte.
REQ-027 SHALL send bytes in write order.
REQ-028 flush=1 at an edge SHALL set level=0 and read pointer = write pointer.
REQ-029 flush SHALL NOT abort the byte in START/WAIT/GAP.
REQ-030 When flush and a write coincide, flush SHALL win and the write is dropped.
REQ-031 When flush and a pop coincide, the pop SHALL proceed and the remainder is flushed.
REQ-032 SHALL drive busy = (state != IDLE) || (level != 0).

Reset
REQ-033 rst_n=0 SHALL immediately force state=IDLE, pointers=0, level=0, tx_data_reg=8'h00, start_transfer=0, gap counter=0, without waiting for clk.
REQ-034 While rst_n=0, wr_ready SHALL be 1 and busy SHALL be 0.
REQ-035 Reset during WAIT SHALL abandon the byte; a later done pulse in IDLE SHALL have no effect.
REQ-036 After rst_n deasserts, the first write SHALL be accepted at the first rising edge.

Verification
REQ-037 Single byte: write 8'hA5 into an empty queue -> one edge later tx_data_reg=A5 and a 1-cycle start_transfer; after done, GAP lasts 2 cycles, then busy=0.
REQ-038 Burst order: write 8'h01..8'h08 back-to-back with DEPTH=8, done modelled 100 cycles after each start -> level peaks at 7 and tx_data_reg shows 01..08 in order, each start exactly GAP_CYCLES+1 cycles after the previous done.
REQ-039 Full: hold the queue at level=8, assert wr_valid with 8'hFF -> wr_ready=0, level stays 8, and FF is never transmitted.
REQ-040 Flush mid-transfer: queue 3 bytes (first in WAIT), pulse flush -> level=0, the in-flight byte completes on done, and no further start_transfer.
REQ-041 Spurious done: pulse done in IDLE and in START -> no state change; in START, start_transfer stays 1 for only 1 cycle.
REQ-042 Async reset: assert rst_n=0 mid-WAIT between clk edges -> outputs take reset values immediately, and the queue is empty after release.
